// File: rtl/fifo_byte_serializer_if.sv
// Byte-serializer bus bundle: FIFO show-ahead read port plus byte valid/ready stream.
// m_par_o exists only when SER_PARITY_EN is defined.
interface fifo_byte_serializer_if #(
    parameter int DWID = 16
);
    logic            fifo_empty_i;
    logic [DWID-1:0] fifo_rdata_i;
    logic            fifo_rd_o;
    logic            m_valid_o;
    logic            m_ready_i;
    logic [7:0]      m_data_o;
`ifdef SER_PARITY_EN
    logic            m_par_o;

    modport master (
        input  fifo_empty_i, fifo_rdata_i, m_ready_i,
        output fifo_rd_o, m_valid_o, m_data_o, m_par_o
    );
    modport slave (
        output fifo_empty_i, fifo_rdata_i, m_ready_i,
        input  fifo_rd_o, m_valid_o, m_data_o, m_par_o
    );
`else
    modport master (
        input  fifo_empty_i, fifo_rdata_i, m_ready_i,
        output fifo_rd_o, m_valid_o, m_data_o
    );
    modport slave (
        output fifo_empty_i, fifo_rdata_i, m_ready_i,
        input  fifo_rd_o, m_valid_o, m_data_o
    );
`endif
endinterface

// File: rtl/fifo_byte_serializer.sv
// Drains DWID-bit words from a show-ahead FIFO and emits them MSB byte first on valid/ready.
// Optional SER_PARITY_EN adds a registered even-parity bit m_par_o.
module fifo_byte_serializer #(
    parameter int DWID    = 16,
    parameter int CNT_WID = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en_i,
    fifo_byte_serializer_if.master ser_if,
    output logic                   busy_o,
    output logic [CNT_WID-1:0]     word_cnt_o
);
    localparam int NBYTES = DWID / 8;
    localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [DWID-1:0]    word_q, word_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [CNT_WID-1:0] cnt_q, cnt_d;
    logic               accept_s;
    logic               last_acc_s;
    logic               pop_s;

    // Next-state, pop decision and datapath update; word_q shifts so its top byte is always the byte on the wire
    always_comb begin
        state_d    = state_q;
        word_d     = word_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        accept_s   = (state_q == SEND) && ser_if.m_ready_i;
        last_acc_s = accept_s && (idx_q == LAST_IDX);
        pop_s      = !rst && en_i && !ser_if.fifo_empty_i &&
                     ((state_q == IDLE) || last_acc_s);
        case (state_q)
            IDLE: begin
                if (pop_s) begin
                    word_d  = ser_if.fifo_rdata_i;
                    idx_d   = {IDX_W{1'b0}};
                    state_d = SEND;
                end else begin
                    state_d = IDLE;
                end
            end
            SEND: begin
                if (last_acc_s) begin
                    cnt_d = cnt_q + CNT_WID'(1);
                    if (pop_s) begin
                        word_d = ser_if.fifo_rdata_i;
                        idx_d  = {IDX_W{1'b0}};
                    end else begin
                        state_d = IDLE;
                    end
                end else if (accept_s) begin
                    word_d = word_q << 4'd8;
                    idx_d  = idx_q + IDX_W'(1);
                end else begin
                    state_d = SEND;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            word_q  <= {DWID{1'b0}};
            idx_q   <= {IDX_W{1'b0}};
            cnt_q   <= {CNT_WID{1'b0}};
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef SER_PARITY_EN
    logic par_q;

    // Parity is registered from the next top byte so it lines up with m_data_o
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            par_q <= 1'b0;
        end else begin
            par_q <= ^word_d[DWID-1 -: 8];
        end
    end

    assign ser_if.m_par_o = par_q;
`endif

    assign ser_if.fifo_rd_o = pop_s;
    assign ser_if.m_valid_o = (state_q == SEND);
    assign ser_if.m_data_o  = word_q[DWID-1 -: 8];
    assign busy_o           = (state_q == SEND);
    assign word_cnt_o       = cnt_q;

endmodule
